// File: rtl/alu_operand_collector_if.sv
// Operand/command bus between an operand source and the ALU operand collector.
// The source drives operands with per-operand valid flags; the collector returns completed sets.
interface alu_operand_collector_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  CE;
    logic                  MODE;
    logic [3:0]            CMD;
    logic                  CIN;
    logic [DATA_WIDTH-1:0] OPA;
    logic [DATA_WIDTH-1:0] OPB;
    logic [1:0]            INP_VALID;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_opa;
    logic [DATA_WIDTH-1:0] out_opb;
    logic [3:0]            out_cmd;
    logic                  out_mode;
    logic                  out_cin;
    logic                  ERR;
    logic                  busy;

    modport master (
        output CE, MODE, CMD, CIN, OPA, OPB, INP_VALID,
        input  out_valid, out_opa, out_opb, out_cmd, out_mode, out_cin, ERR, busy
    );

    modport slave (
        input  CE, MODE, CMD, CIN, OPA, OPB, INP_VALID,
        output out_valid, out_opa, out_opb, out_cmd, out_mode, out_cin, ERR, busy
    );
endinterface

// File: rtl/alu_operand_collector.sv
// Collects the operands an ALU command needs, possibly across cycles, and issues the set
// as a registered one-cycle pulse; a set missing an operand for TIMEOUT cycles is dropped.
module alu_operand_collector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_collector_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWaitA = 2'd1;
    localparam logic [1:0] StWaitB = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [3:0]            cmd_q, cmd_d;
    logic                  mode_q, mode_d, cin_q, cin_d;
    logic                  valid_q, valid_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] out_opa_q, out_opa_d, out_opb_q, out_opb_d;
    logic [3:0]            out_cmd_q, out_cmd_d;
    logic                  out_mode_q, out_mode_d, out_cin_q, out_cin_d;
    logic                  need_a, need_b, covers, wait_hit;

    always_comb begin
        need_a = 1'b1;
        need_b = 1'b1;
        if (bus.MODE) begin
            if (bus.CMD inside {4'd4, 4'd5}) need_b = 1'b0;
            if (bus.CMD inside {4'd6, 4'd7}) need_a = 1'b0;
        end else begin
            if (bus.CMD inside {4'd6, 4'd8, 4'd9})   need_b = 1'b0;
            if (bus.CMD inside {4'd7, 4'd10, 4'd11}) need_a = 1'b0;
        end
    end

    assign covers   = (!need_a || bus.INP_VALID[0]) && (!need_b || bus.INP_VALID[1]);
    assign wait_hit = ((state_q == StWaitA) && bus.INP_VALID[0]) ||
                      ((state_q == StWaitB) && bus.INP_VALID[1]);
    assign cnt_inc  = cnt_q + CntW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cmd_d      = cmd_q;
        mode_d     = mode_q;
        cin_d      = cin_q;
        out_opa_d  = out_opa_q;
        out_opb_d  = out_opb_q;
        out_cmd_d  = out_cmd_q;
        out_mode_d = out_mode_q;
        out_cin_d  = out_cin_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (bus.CE) begin
            case (state_q)
                StIdle: begin
                    // Inputs are ignored while the previous result/error pulse is on the bus.
                    if (!valid_q && !err_q && (bus.INP_VALID != 2'b00)) begin
                        if (covers) begin
                            valid_d    = 1'b1;
                            out_opa_d  = bus.OPA;
                            out_opb_d  = bus.OPB;
                            out_cmd_d  = bus.CMD;
                            out_mode_d = bus.MODE;
                            out_cin_d  = bus.CIN;
                        end else begin
                            cmd_d  = bus.CMD;
                            mode_d = bus.MODE;
                            cin_d  = bus.CIN;
                            cnt_d  = '0;
                            if (need_a && bus.INP_VALID[0]) opa_d = bus.OPA;
                            if (need_b && bus.INP_VALID[1]) opb_d = bus.OPB;
                            state_d = (need_a && !bus.INP_VALID[0]) ? StWaitA : StWaitB;
                        end
                    end
                end
                StWaitA, StWaitB: begin
                    if (wait_hit) begin
                        valid_d    = 1'b1;
                        out_opa_d  = (state_q == StWaitA) ? bus.OPA : opa_q;
                        out_opb_d  = (state_q == StWaitB) ? bus.OPB : opb_q;
                        out_cmd_d  = cmd_q;
                        out_mode_d = mode_q;
                        out_cin_d  = cin_q;
                        cnt_d      = '0;
                        state_d    = StIdle;
                    end else if (cnt_inc == CntW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            cmd_q      <= '0;
            mode_q     <= 1'b0;
            cin_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            out_opa_q  <= '0;
            out_opb_q  <= '0;
            out_cmd_q  <= '0;
            out_mode_q <= 1'b0;
            out_cin_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cmd_q      <= cmd_d;
            mode_q     <= mode_d;
            cin_q      <= cin_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            out_opa_q  <= out_opa_d;
            out_opb_q  <= out_opb_d;
            out_cmd_q  <= out_cmd_d;
            out_mode_q <= out_mode_d;
            out_cin_q  <= out_cin_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.ERR       = err_q;
    assign bus.busy      = (state_q == StWaitA) || (state_q == StWaitB);
    assign bus.out_opa   = out_opa_q;
    assign bus.out_opb   = out_opb_q;
    assign bus.out_cmd   = out_cmd_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.out_cin   = out_cin_q;
endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: issue, split arrival, timeout, CE freeze and
// asynchronous reset, with hand-computed expectations.
module tb_alu_operand_collector;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_operand_collector_if #(.DATA_WIDTH(8)) bus ();

    alu_operand_collector #(
        .DATA_WIDTH(8),
        .TIMEOUT   (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.MODE      = mode;
        bus.CMD       = cmd;
        bus.INP_VALID = iv;
        bus.OPA       = a;
        bus.OPB       = b;
        bus.CIN       = cin;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.CE = 1'b0;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        #3;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_err",   {31'd0, bus.ERR}, 32'd0);
        check("rst_opa",   {24'd0, bus.out_opa}, 32'd0);
        #4;
        rst    = 1'b1;
        bus.CE = 1'b1;

        // Both operands present: immediate issue.
        drive(1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0);
        tick();
        check("imm_valid", {31'd0, bus.out_valid}, 32'd1);
        check("imm_opa",   {24'd0, bus.out_opa}, 32'h12);
        check("imm_opb",   {24'd0, bus.out_opb}, 32'h34);
        check("imm_busy",  {31'd0, bus.busy}, 32'd0);
        check("imm_mode",  {31'd0, bus.out_mode}, 32'd1);
        drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        check("imm_pulse", {31'd0, bus.out_valid}, 32'd0);
        check("imm_hold",  {24'd0, bus.out_opa}, 32'h12);

        // OPA first, OPB on waiting cycle 16 (the last legal one).
        drive(1'b1, 4'd0, 2'b01, 8'hA5, 8'h00, 1'b1);
        tick();
        check("wb_busy", {31'd0, bus.busy}, 32'd1);
        drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (15) tick();
        check("wb_noerr15", {31'd0, bus.ERR}, 32'd0);
        check("wb_busy15",  {31'd0, bus.busy}, 32'd1);
        drive(1'b0, 4'd3, 2'b10, 8'h77, 8'h5A, 1'b0);
        tick();
        check("wb_valid", {31'd0, bus.out_valid}, 32'd1);
        check("wb_opa",   {24'd0, bus.out_opa}, 32'hA5);
        check("wb_opb",   {24'd0, bus.out_opb}, 32'h5A);
        check("wb_cmd",   {28'd0, bus.out_cmd}, 32'd0);
        check("wb_cin",   {31'd0, bus.out_cin}, 32'd1);
        check("wb_err",   {31'd0, bus.ERR}, 32'd0);

        // A full set offered during the out_valid cycle is ignored, then taken next cycle.
        drive(1'b0, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0);
        tick();
        check("blk_valid", {31'd0, bus.out_valid}, 32'd0);
        check("blk_opa",   {24'd0, bus.out_opa}, 32'hA5);
        tick();
        check("nxt_valid", {31'd0, bus.out_valid}, 32'd1);
        check("nxt_opa",   {24'd0, bus.out_opa}, 32'h01);
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();

        // OPB first, OPA never arrives: ERR after waiting cycle 16.
        drive(1'b0, 4'd1, 2'b10, 8'h00, 8'h0F, 1'b0);
        tick();
        check("to_busy", {31'd0, bus.busy}, 32'd1);
        drive(1'b0, 4'd1, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (15) tick();
        check("to_noerr15", {31'd0, bus.ERR}, 32'd0);
        tick();
        check("to_err",   {31'd0, bus.ERR}, 32'd1);
        check("to_valid", {31'd0, bus.out_valid}, 32'd0);
        check("to_busy0", {31'd0, bus.busy}, 32'd0);
        check("to_opb",   {24'd0, bus.out_opb}, 32'h02);
        tick();
        check("to_pulse", {31'd0, bus.ERR}, 32'd0);

        // Single-operand commands.
        drive(1'b1, 4'd4, 2'b01, 8'hFF, 8'h00, 1'b0);
        tick();
        check("a_only_valid", {31'd0, bus.out_valid}, 32'd1);
        check("a_only_opa",   {24'd0, bus.out_opa}, 32'hFF);
        drive(1'b1, 4'd4, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 4'd6, 2'b01, 8'h11, 8'h00, 1'b0);
        tick();
        check("b_only_busy",  {31'd0, bus.busy}, 32'd1);
        check("b_only_nov",   {31'd0, bus.out_valid}, 32'd0);
        drive(1'b0, 4'd0, 2'b10, 8'h00, 8'hC3, 1'b0);
        tick();
        check("b_only_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b_only_opb",   {24'd0, bus.out_opb}, 32'hC3);
        check("b_only_cmd",   {28'd0, bus.out_cmd}, 32'd6);
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b0, 4'd7, 2'b10, 8'h00, 8'h3C, 1'b0);
        tick();
        check("log_b_valid", {31'd0, bus.out_valid}, 32'd1);
        check("log_b_opb",   {24'd0, bus.out_opb}, 32'h3C);
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();

        // CE low freezes the wait counter.
        drive(1'b1, 4'd0, 2'b01, 8'h05, 8'h00, 1'b0);
        tick();
        drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (5) tick();
        bus.CE = 1'b0;
        repeat (10) tick();
        check("ce_noerr", {31'd0, bus.ERR}, 32'd0);
        check("ce_busy",  {31'd0, bus.busy}, 32'd1);
        bus.CE = 1'b1;
        repeat (10) tick();
        check("ce_noerr10", {31'd0, bus.ERR}, 32'd0);
        tick();
        check("ce_err11", {31'd0, bus.ERR}, 32'd1);
        tick();

        // Asynchronous reset mid-wait, then normal operation.
        drive(1'b0, 4'd0, 2'b10, 8'h00, 8'h09, 1'b0);
        tick();
        check("ar_busy", {31'd0, bus.busy}, 32'd1);
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_busy0", {31'd0, bus.busy}, 32'd0);
        check("ar_opa0",  {24'd0, bus.out_opa}, 32'd0);
        check("ar_opb0",  {24'd0, bus.out_opb}, 32'd0);
        check("ar_cmd0",  {28'd0, bus.out_cmd}, 32'd0);
        #1;
        rst = 1'b1;
        drive(1'b1, 4'd2, 2'b11, 8'hAA, 8'hBB, 1'b1);
        tick();
        check("ar_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ar_opa",   {24'd0, bus.out_opa}, 32'hAA);
        check("ar_opb",   {24'd0, bus.out_opb}, 32'hBB);
        check("ar_cmd",   {28'd0, bus.out_cmd}, 32'd2);
        check("ar_cin",   {31'd0, bus.out_cin}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
